// File: rtl/timer_ctrl.sv
// Host-side controller for the timer IO device: register file, arm/settle FSM, tear-free timestamp.
// Optional TIMER_PERIODIC_EN: periodic auto re-arm and overrun detection.
module timer_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [63:0] timer_input,
    output logic        reset_timer,
    output logic        reset_timestamp,
    output logic        enable_clock,
    input  logic        warn,
    input  logic [63:0] timestamp
);
    localparam int CW = $clog2(SETTLE_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, ARM, SETTLE, RUN, EXPIRED} state_t;

    state_t                 state;
    logic [CW-1:0]          settle_cnt;
    logic [SYNC_STAGES-1:0] warn_sync;
    logic [63:0]            load;
    logic [31:0]            ts_hi;
    logic                   irq_en;
    logic                   pending;
    logic                   err;
    logic                   overrun;
    logic                   periodic;
    logic                   warn_s;
    logic                   wr_ctrl;
    logic                   wr_stat;
    logic                   start;
    logic                   stop;
    logic                   running;
    logic                   unused_wdata;

    assign warn_s  = warn_sync[SYNC_STAGES-1];
    assign wr_ctrl = we && (addr == 3'd0);
    assign wr_stat = we && (addr == 3'd1);
    assign start   = wr_ctrl && wdata[1];
    assign stop    = wr_ctrl && wdata[2];
    assign running = (state == ARM) || (state == SETTLE) || (state == RUN);
    assign unused_wdata = &{1'b0, wdata[31:5]};

`ifdef TIMER_PERIODIC_EN
    always_ff @(posedge clk) begin
        if (reset)
            periodic <= 1'b0;
        else if (wr_ctrl)
            periodic <= wdata[5];
    end
`else
    assign periodic = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            warn_sync <= '0;
        else
            warn_sync <= {warn_sync[SYNC_STAGES-2:0], warn};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            load            <= '0;
            timer_input     <= '0;
            reset_timer     <= 1'b0;
            reset_timestamp <= 1'b0;
            enable_clock    <= 1'b0;
            irq_en          <= 1'b0;
            pending         <= 1'b0;
            err             <= 1'b0;
            overrun         <= 1'b0;
            irq             <= 1'b0;
        end else begin
            reset_timer     <= 1'b0;
            reset_timestamp <= wr_ctrl && wdata[3];
            irq             <= pending && irq_en;
            if (wr_ctrl) begin
                enable_clock <= wdata[0];
                irq_en       <= wdata[4];
            end
            if (we && addr == 3'd2) load[31:0]  <= wdata;
            if (we && addr == 3'd3) load[63:32] <= wdata;
            if (wr_stat) begin
                if (wdata[1]) pending <= 1'b0;
                if (wdata[2]) err     <= 1'b0;
                if (wdata[3]) overrun <= 1'b0;
            end
            if (stop) begin
                state       <= IDLE;
                timer_input <= '0;
            end else if (start) begin
                if (state == IDLE && load == '0) begin
                    err <= 1'b1;
                end else begin
                    if (state != IDLE) pending <= 1'b0;
                    state       <= ARM;
                    timer_input <= load;
                    reset_timer <= 1'b1;
                end
            end else begin
                case (state)
                    ARM: begin
                        state      <= SETTLE;
                        settle_cnt <= CW'(SETTLE_CYCLES);
                    end
                    SETTLE: begin
                        if (settle_cnt <= CW'(1))
                            state <= RUN;
                        else
                            settle_cnt <= settle_cnt - CW'(1);
                    end
                    RUN: begin
                        if (warn_s) begin
                            pending <= 1'b1;
`ifdef TIMER_PERIODIC_EN
                            if (pending) overrun <= 1'b1;
`endif
                            // periodic re-arm reuses the alarm already armed
                            if (periodic) begin
                                state       <= ARM;
                                reset_timer <= 1'b1;
                            end else begin
                                state <= EXPIRED;
                            end
                        end
                    end
                    EXPIRED: begin
                        if (wr_stat && wdata[1]) begin
                            state       <= IDLE;
                            timer_input <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // TS_LO read captures the upper half so TS_HI pairs with it
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
            ts_hi <= '0;
        end else if (re) begin
            case (addr)
                3'd0: rdata <= {26'd0, periodic, irq_en, 3'd0, enable_clock};
                3'd1: rdata <= {28'd0, overrun, err, pending, running};
                3'd2: rdata <= load[31:0];
                3'd3: rdata <= load[63:32];
                3'd4: begin
                    rdata <= timestamp[31:0];
                    ts_hi <= timestamp[63:32];
                end
                3'd5: rdata <= ts_hi;
                default: rdata <= '0;
            endcase
        end
    end
endmodule
